mac_stream_loader: RTL and testbench

Write-side sequencer for the MAC engine's two input FIFOs. On a start command it loads `NUM_TAPS` coefficient words into the coefficient FIFO, then streams `NUM_TAPS` signal samples into the signal FIFO, throttled by the FIFO full flags. It then waits for the pipeline to drain and returns the accumulated result on a valid/ready stream. It sits between the upstream sample/coefficient sources and the MAC's FIFO write ports.

---
 rtl/mac_pkg.sv | 18 +
 rtl/mac_stream_loader_if.sv | 68 ++++++
 rtl/mac_stream_loader_push_stage.sv | 30 +++
 rtl/mac_stream_loader.sv | 176 +++++++++++++++++
 tb/tb_mac_stream_loader.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and default constants for the MAC stream loader slice.
// Holds the loader FSM state type and the width/drain defaults that the
// interface, the push stage and the top module all build on.
package mac_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 32;
    localparam int DEFAULT_ADDR_LINES   = 4;
    localparam int DEFAULT_DRAIN_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_COEFF,
        STREAM,
        DRAIN,
        OUTPUT
    } loader_state_t;

endpackage

// File: rtl/mac_stream_loader_if.sv
// Bundle of every non-clock, non-reset signal of the MAC stream loader.
// The slave modport is the loader's own view; the master modport is the
// surrounding environment (sources, MAC FIFOs, result sink).
// Optional reload_i exists only when MAC_LOADER_COEFF_RELOAD_EN is defined.
interface mac_stream_loader_if #(
    parameter int DATA_WIDTH = mac_pkg::DEFAULT_DATA_WIDTH
);

    logic                  start_i;
`ifdef MAC_LOADER_COEFF_RELOAD_EN
    logic                  reload_i;
`endif
    logic [DATA_WIDTH-1:0] coeff_data_i;
    logic                  coeff_valid_i;
    logic                  coeff_ready_o;
    logic [DATA_WIDTH-1:0] sample_data_i;
    logic                  sample_valid_i;
    logic                  sample_ready_o;
    logic [DATA_WIDTH-1:0] coeff_fifo_o;
    logic                  coeff_push_o;
    logic [DATA_WIDTH-1:0] signal_fifo_o;
    logic                  signal_push_o;
    logic                  full_adder_i;
    logic                  full_mul_i;
    logic                  empty_mul_i;
    logic [DATA_WIDTH-1:0] result_i;
    logic [DATA_WIDTH-1:0] result_o;
    logic                  result_valid_o;
    logic                  result_ready_i;
    logic                  busy_o;

    modport slave (
`ifdef MAC_LOADER_COEFF_RELOAD_EN
        input  reload_i,
`endif
        input  start_i,
        input  coeff_data_i, coeff_valid_i,
        output coeff_ready_o,
        input  sample_data_i, sample_valid_i,
        output sample_ready_o,
        output coeff_fifo_o, coeff_push_o,
        output signal_fifo_o, signal_push_o,
        input  full_adder_i, full_mul_i, empty_mul_i,
        input  result_i,
        output result_o, result_valid_o,
        input  result_ready_i,
        output busy_o
    );

    modport master (
`ifdef MAC_LOADER_COEFF_RELOAD_EN
        output reload_i,
`endif
        output start_i,
        output coeff_data_i, coeff_valid_i,
        input  coeff_ready_o,
        output sample_data_i, sample_valid_i,
        input  sample_ready_o,
        input  coeff_fifo_o, coeff_push_o,
        input  signal_fifo_o, signal_push_o,
        output full_adder_i, full_mul_i, empty_mul_i,
        output result_i,
        input  result_o, result_valid_o,
        output result_ready_i,
        input  busy_o
    );

endinterface

// File: rtl/mac_stream_loader_push_stage.sv
// Push stage for one MAC FIFO write port: registers the handshaked word
// and raises a one-cycle write strobe. The data port keeps its last word
// between pushes, and reset drops any word that was about to be written.
module loader_push_stage
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  push_o
);

    // Capture the accepted word and strobe the FIFO write one cycle later
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_o <= '0;
            push_o <= 1'b0;
        end else begin
            push_o <= load_i;
            if (load_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/mac_stream_loader.sv
// MAC stream loader: on start, writes NUM_TAPS coefficients into the
// coefficient FIFO, then NUM_TAPS samples into the signal FIFO, waits for
// the multiplier FIFO to stay empty for DRAIN_CYCLES, and offers the MAC
// result on a valid/ready stream.
// Optional feature: MAC_LOADER_COEFF_RELOAD_EN adds reload_i so a start
// may skip the coefficient load and reuse what the FIFO already holds.
module mac_stream_loader
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_LINES   = DEFAULT_ADDR_LINES,
    parameter int NUM_TAPS     = 8,
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    mac_stream_loader_if.slave  bus
);

    localparam int FIFO_DEPTH = 1 << ADDR_LINES;
    localparam int TAP_W      = $clog2(NUM_TAPS + 1);
    localparam int DRAIN_W    = $clog2(DRAIN_CYCLES + 1);

    localparam logic [TAP_W-1:0]   TAP_LIMIT  = TAP_W'(NUM_TAPS);
    localparam logic [TAP_W-1:0]   LAST_TAP   = TAP_W'(NUM_TAPS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    // A frame larger than the FIFO could never be fully written
    if (NUM_TAPS < 1 || NUM_TAPS > FIFO_DEPTH) begin : g_num_taps_check
        $error("mac_stream_loader: NUM_TAPS must lie in 1..2**ADDR_LINES");
    end

    loader_state_t        state;
    loader_state_t        state_next;
    logic [TAP_W-1:0]     tap_cnt;
    logic [TAP_W-1:0]     tap_cnt_next;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [DRAIN_W-1:0]   drain_cnt_next;
    logic [DATA_WIDTH-1:0] result_q;
    logic                 capture;
    logic                 coeff_ready;
    logic                 sample_ready;
    logic                 coeff_hs;
    logic                 sample_hs;
`ifdef MAC_LOADER_COEFF_RELOAD_EN
    logic                 coeff_loaded;
    logic                 coeff_loaded_next;
`endif

    // Next-state, counter and ready logic; ready follows the full flags
    // combinationally so a flag rising blocks the handshake in that cycle
    always_comb begin
        state_next     = state;
        tap_cnt_next   = tap_cnt;
        drain_cnt_next = '0;
        capture        = 1'b0;
`ifdef MAC_LOADER_COEFF_RELOAD_EN
        coeff_loaded_next = coeff_loaded;
`endif
        coeff_ready  = (state == LOAD_COEFF) && !bus.full_adder_i && (tap_cnt < TAP_LIMIT);
        sample_ready = (state == STREAM) && !bus.full_mul_i && (tap_cnt < TAP_LIMIT);
        coeff_hs     = coeff_ready && bus.coeff_valid_i;
        sample_hs    = sample_ready && bus.sample_valid_i;

        case (state)
            IDLE: begin
                if (bus.start_i) begin
`ifdef MAC_LOADER_COEFF_RELOAD_EN
                    if (bus.reload_i || !coeff_loaded) begin
                        state_next = LOAD_COEFF;
                    end else begin
                        state_next = STREAM;
                    end
`else
                    state_next = LOAD_COEFF;
`endif
                end
            end
            LOAD_COEFF: begin
                if (coeff_hs) begin
                    if (tap_cnt == LAST_TAP) begin
                        state_next = STREAM;
`ifdef MAC_LOADER_COEFF_RELOAD_EN
                        coeff_loaded_next = 1'b1;
`endif
                    end else begin
                        tap_cnt_next = tap_cnt + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (sample_hs) begin
                    if (tap_cnt == LAST_TAP) begin
                        state_next = DRAIN;
                    end else begin
                        tap_cnt_next = tap_cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (bus.empty_mul_i) begin
                    if (drain_cnt == DRAIN_LAST) begin
                        capture    = 1'b1;
                        state_next = OUTPUT;
                    end else begin
                        drain_cnt_next = drain_cnt + 1'b1;
                    end
                end
            end
            OUTPUT: begin
                if (bus.result_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next != state) begin
            tap_cnt_next = '0;
        end
    end

    // State, counters and the captured result; reset returns to IDLE
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            tap_cnt   <= '0;
            drain_cnt <= '0;
            result_q  <= '0;
`ifdef MAC_LOADER_COEFF_RELOAD_EN
            coeff_loaded <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            tap_cnt   <= tap_cnt_next;
            drain_cnt <= drain_cnt_next;
            if (capture) begin
                result_q <= bus.result_i;
            end
`ifdef MAC_LOADER_COEFF_RELOAD_EN
            coeff_loaded <= coeff_loaded_next;
`endif
        end
    end

    assign bus.coeff_ready_o  = coeff_ready;
    assign bus.sample_ready_o = sample_ready;
    assign bus.result_o       = result_q;
    assign bus.result_valid_o = (state == OUTPUT);
    assign bus.busy_o         = (state != IDLE);

    loader_push_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_coeff_push (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .load_i (coeff_hs),
        .data_i (bus.coeff_data_i),
        .data_o (bus.coeff_fifo_o),
        .push_o (bus.coeff_push_o)
    );

    loader_push_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_signal_push (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .load_i (sample_hs),
        .data_i (bus.sample_data_i),
        .data_o (bus.signal_fifo_o),
        .push_o (bus.signal_push_o)
    );

endmodule

// File: tb/tb_mac_stream_loader.sv
// Testbench for mac_stream_loader with NUM_TAPS=4, DRAIN_CYCLES=2.
// A frame-level model decides, cycle by cycle, what the loader must do:
// which readies are allowed, which words get pushed one cycle after their
// handshake, which result_i value is taken after the multiplier FIFO has
// stayed empty long enough, and how long the result is held.
module tb_mac_stream_loader;

    localparam int DW    = 32;
    localparam int NT    = 4;
    localparam int DRAIN = 2;

    logic clk = 1'b0;
    logic rstn;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] coeff_q[$];
    logic [DW-1:0] sample_q[$];
    logic [DW-1:0] coeff_seen[$];
    logic [DW-1:0] signal_seen[$];

    bit            prev_c_hs;
    bit            prev_s_hs;
    logic [DW-1:0] prev_c_word;
    logic [DW-1:0] prev_s_word;
    logic [DW-1:0] last_c;
    logic [DW-1:0] last_s;
    bit            model_loaded;

    int            cfg_valid_pct;
    int            cfg_full_pct;
    int            cfg_hold_at;
    int            cfg_rready_delay;
    bit            cfg_drain_toggle;
    int            cfg_empty_delay;
    bit            cfg_res_fixed;
    logic [DW-1:0] cfg_res_value;
    bit            cfg_start_in_output;
    bit            cfg_reload;

    mac_stream_loader_if #(.DATA_WIDTH(DW)) bus ();

    mac_stream_loader #(
        .DATA_WIDTH   (DW),
        .ADDR_LINES   (4),
        .NUM_TAPS     (NT),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Record every FIFO write, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.coeff_push_o === 1'b1) coeff_seen.push_back(bus.coeff_fifo_o);
        if (bus.signal_push_o === 1'b1) signal_seen.push_back(bus.signal_fifo_o);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        cfg_valid_pct       = 100;
        cfg_full_pct        = 0;
        cfg_hold_at         = -1;
        cfg_rready_delay    = 0;
        cfg_drain_toggle    = 1'b0;
        cfg_empty_delay     = 0;
        cfg_res_fixed       = 1'b0;
        cfg_res_value       = '0;
        cfg_start_in_output = 1'b0;
        cfg_reload          = 1'b1;
    endtask

    task automatic fill_random();
        coeff_q.delete();
        sample_q.delete();
        for (int i = 0; i < NT; i++) begin
            coeff_q.push_back($urandom());
            sample_q.push_back($urandom());
        end
    endtask

    task automatic idle_inputs();
        bus.start_i        = 1'b0;
`ifdef MAC_LOADER_COEFF_RELOAD_EN
        bus.reload_i       = 1'b0;
`endif
        bus.coeff_data_i   = '0;
        bus.coeff_valid_i  = 1'b0;
        bus.sample_data_i  = '0;
        bus.sample_valid_i = 1'b0;
        bus.full_adder_i   = 1'b0;
        bus.full_mul_i     = 1'b0;
        bus.empty_mul_i    = 1'b0;
        bus.result_i       = '0;
        bus.result_ready_i = 1'b0;
    endtask

    // Drive one complete frame from IDLE back to IDLE against the model
    task automatic run_frame();
        int phase;
        int cidx;
        int sidx;
        int high_run;
        int dcyc;
        int out_k;
        int guard;
        int hold_left;
        bit hold_done;
        bit load;
        bit emp;
        bit start_pulsed;
        logic [DW-1:0] cap;
        logic [DW-1:0] want;

        phase = 0; cidx = 0; sidx = 0; high_run = 0; dcyc = 0; out_k = 0;
        guard = 0; hold_left = 0; hold_done = 1'b0; start_pulsed = 1'b0; cap = '0;
        load = 1'b1;
`ifdef MAC_LOADER_COEFF_RELOAD_EN
        load = cfg_reload || !model_loaded;
`endif
        coeff_seen.delete();
        signal_seen.delete();

        checks++;
        if (bus.busy_o !== 1'b0 || bus.result_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_status: busy=%b valid=%b, want 0/0", bus.busy_o, bus.result_valid_o);
        end
        bus.start_i        = 1'b1;
`ifdef MAC_LOADER_COEFF_RELOAD_EN
        bus.reload_i       = cfg_reload;
`endif
        bus.coeff_valid_i  = 1'b1;
        bus.sample_valid_i = 1'b1;
        bus.result_ready_i = 1'b0;
        #1;
        checks++;
        if (bus.coeff_ready_o !== 1'b0 || bus.sample_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_ready: coeff=%b sample=%b, want 0/0", bus.coeff_ready_o, bus.sample_ready_o);
        end
        next_cycle();
        phase = load ? 0 : 1;

        while (phase != 4 && guard < 400) begin
            want = prev_c_hs ? prev_c_word : last_c;
            checks++;
            if (bus.coeff_push_o !== prev_c_hs) begin
                errors++;
                $display("[TB] FAIL coeff_push: got %b want %b", bus.coeff_push_o, prev_c_hs);
            end
            checks++;
            if (bus.coeff_fifo_o !== want) begin
                errors++;
                $display("[TB] FAIL coeff_fifo: got %h want %h", bus.coeff_fifo_o, want);
            end
            last_c = want;
            want = prev_s_hs ? prev_s_word : last_s;
            checks++;
            if (bus.signal_push_o !== prev_s_hs) begin
                errors++;
                $display("[TB] FAIL signal_push: got %b want %b", bus.signal_push_o, prev_s_hs);
            end
            checks++;
            if (bus.signal_fifo_o !== want) begin
                errors++;
                $display("[TB] FAIL signal_fifo: got %h want %h", bus.signal_fifo_o, want);
            end
            last_s = want;
            prev_c_hs = 1'b0;
            prev_s_hs = 1'b0;

            if (phase == 2 && high_run >= DRAIN) phase = 3;

            bus.start_i        = 1'b0;
`ifdef MAC_LOADER_COEFF_RELOAD_EN
            bus.reload_i       = 1'($urandom_range(1));
`endif
            bus.coeff_valid_i  = 1'($urandom_range(1));
            bus.coeff_data_i   = $urandom();
            bus.sample_valid_i = 1'($urandom_range(1));
            bus.sample_data_i  = $urandom();
            bus.full_adder_i   = ($urandom_range(99) < cfg_full_pct);
            bus.full_mul_i     = ($urandom_range(99) < cfg_full_pct);
            bus.empty_mul_i    = 1'($urandom_range(1));
            bus.result_ready_i = 1'b0;
            bus.result_i       = cfg_res_fixed ? cfg_res_value : $urandom();

            case (phase)
                0: begin
                    bus.coeff_valid_i = ($urandom_range(99) < cfg_valid_pct);
                    bus.coeff_data_i  = coeff_q[cidx];
                end
                1: begin
                    if (cfg_hold_at >= 0 && !hold_done && sidx == cfg_hold_at) begin
                        hold_left = 5;
                        hold_done = 1'b1;
                    end
                    bus.sample_valid_i = ($urandom_range(99) < cfg_valid_pct);
                    bus.sample_data_i  = sample_q[sidx];
                    if (hold_left > 0) begin
                        bus.full_mul_i     = 1'b1;
                        bus.sample_valid_i = 1'b1;
                        hold_left--;
                    end
                end
                2: begin
                    if (cfg_drain_toggle) emp = (dcyc != 1);
                    else emp = (dcyc >= cfg_empty_delay);
                    bus.empty_mul_i = emp;
                end
                default: begin
                    bus.result_ready_i = (out_k >= cfg_rready_delay);
                    if (cfg_start_in_output && out_k == 1 && cfg_rready_delay > 1) begin
                        bus.start_i  = 1'b1;
                        start_pulsed = 1'b1;
                    end
                end
            endcase
            #1;

            checks++;
            if (bus.coeff_ready_o !== (phase == 0 && !bus.full_adder_i)) begin
                errors++;
                $display("[TB] FAIL coeff_ready: got %b want %b (phase %0d)", bus.coeff_ready_o,
                         (phase == 0 && !bus.full_adder_i), phase);
            end
            checks++;
            if (bus.sample_ready_o !== (phase == 1 && !bus.full_mul_i)) begin
                errors++;
                $display("[TB] FAIL sample_ready: got %b want %b (phase %0d)", bus.sample_ready_o,
                         (phase == 1 && !bus.full_mul_i), phase);
            end
            checks++;
            if (bus.busy_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL busy: got %b want 1 (phase %0d)", bus.busy_o, phase);
            end
            checks++;
            if (bus.result_valid_o !== (phase == 3)) begin
                errors++;
                $display("[TB] FAIL result_valid: got %b want %b (phase %0d)", bus.result_valid_o, (phase == 3), phase);
            end
            if (phase == 3) begin
                checks++;
                if (bus.result_o !== cap) begin
                    errors++;
                    $display("[TB] FAIL result_o: got %h want %h", bus.result_o, cap);
                end
            end

            case (phase)
                0: begin
                    if (bus.coeff_valid_i && bus.coeff_ready_o) begin
                        prev_c_hs   = 1'b1;
                        prev_c_word = coeff_q[cidx];
                        cidx++;
                        if (cidx == NT) begin
                            phase        = 1;
                            model_loaded = 1'b1;
                        end
                    end
                end
                1: begin
                    if (bus.sample_valid_i && bus.sample_ready_o) begin
                        prev_s_hs   = 1'b1;
                        prev_s_word = sample_q[sidx];
                        sidx++;
                        if (sidx == NT) phase = 2;
                    end
                end
                2: begin
                    if (bus.empty_mul_i) begin
                        high_run++;
                        if (high_run == DRAIN) cap = bus.result_i;
                    end else begin
                        high_run = 0;
                    end
                    dcyc++;
                end
                default: begin
                    if (bus.result_ready_i) phase = 4;
                    out_k++;
                end
            endcase
            next_cycle();
            guard++;
        end

        if (guard >= 400) begin
            errors++;
            $display("[TB] FAIL frame_timeout: stuck in phase %0d, want frame end", phase);
        end
        bus.start_i        = 1'b0;
        bus.result_ready_i = 1'b0;
        bus.coeff_valid_i  = 1'b0;
        bus.sample_valid_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.result_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_end: busy=%b valid=%b, want 0/0", bus.busy_o, bus.result_valid_o);
        end
        if (start_pulsed) begin
            next_cycle();
            checks++;
            if (bus.busy_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL start_ignored: busy=%b want 0", bus.busy_o);
            end
        end

        checks++;
        if (signal_seen.size() != NT) begin
            errors++;
            $display("[TB] FAIL sample_count: got %0d want %0d", signal_seen.size(), NT);
        end
        for (int i = 0; i < NT && i < signal_seen.size(); i++) begin
            checks++;
            if (signal_seen[i] !== sample_q[i]) begin
                errors++;
                $display("[TB] FAIL sample_word[%0d]: got %h want %h", i, signal_seen[i], sample_q[i]);
            end
        end
        checks++;
        if (coeff_seen.size() != (load ? NT : 0)) begin
            errors++;
            $display("[TB] FAIL coeff_count: got %0d want %0d", coeff_seen.size(), (load ? NT : 0));
        end
        if (load) begin
            for (int i = 0; i < NT && i < coeff_seen.size(); i++) begin
                checks++;
                if (coeff_seen[i] !== coeff_q[i]) begin
                    errors++;
                    $display("[TB] FAIL coeff_word[%0d]: got %h want %h", i, coeff_seen[i], coeff_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rstn = 1'b0;
        idle_inputs();
        prev_c_hs = 1'b0; prev_s_hs = 1'b0; last_c = '0; last_s = '0; model_loaded = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.coeff_fifo_o, bus.signal_fifo_o, bus.result_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h/%h/%h want 0", bus.coeff_fifo_o, bus.signal_fifo_o, bus.result_o);
        end
        checks++;
        if ({bus.coeff_push_o, bus.signal_push_o, bus.coeff_ready_o, bus.sample_ready_o,
             bus.result_valid_o, bus.busy_o} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b want 000000", {bus.coeff_push_o, bus.signal_push_o,
                     bus.coeff_ready_o, bus.sample_ready_o, bus.result_valid_o, bus.busy_o});
        end
        @(posedge clk);
        #3;
        rstn = 1'b1;
        next_cycle();
        checks++;
        if (bus.coeff_push_o !== 1'b0 || bus.signal_push_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_cycle: push=%b%b busy=%b want 0", bus.coeff_push_o, bus.signal_push_o, bus.busy_o);
        end
    endtask

    task automatic test_basic();
        $display("[TB] test_basic");
        set_defaults();
        coeff_q  = '{32'd1, 32'd2, 32'd3, 32'd4};
        sample_q = '{32'd5, 32'd6, 32'd7, 32'd8};
        cfg_res_fixed = 1'b1;
        cfg_res_value = 32'd70;
        run_frame();
        checks++;
        if (bus.result_o !== 32'd70) begin
            errors++;
            $display("[TB] FAIL basic_result_hold: got %0d want 70", bus.result_o);
        end
    endtask

    task automatic test_full_backpressure();
        $display("[TB] test_full_backpressure");
        set_defaults();
        fill_random();
        cfg_hold_at = 2;
        run_frame();
    endtask

    task automatic test_result_backpressure();
        $display("[TB] test_result_backpressure");
        set_defaults();
        fill_random();
        cfg_rready_delay    = 10;
        cfg_start_in_output = 1'b1;
        run_frame();
    endtask

    task automatic test_reset_mid();
        $display("[TB] test_reset_mid");
        set_defaults();
        bus.start_i = 1'b1;
        next_cycle();
        bus.start_i       = 1'b0;
        bus.full_adder_i  = 1'b0;
        bus.coeff_valid_i = 1'b1;
        bus.coeff_data_i  = 32'hA1A1_0001;
        next_cycle();
        bus.coeff_data_i  = 32'hA2A2_0002;
        next_cycle();
        bus.coeff_valid_i = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.coeff_fifo_o, bus.signal_fifo_o, bus.result_o} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset_data: got %h/%h/%h want 0", bus.coeff_fifo_o, bus.signal_fifo_o, bus.result_o);
        end
        checks++;
        if ({bus.coeff_push_o, bus.signal_push_o, bus.coeff_ready_o, bus.sample_ready_o,
             bus.result_valid_o, bus.busy_o} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_flags: got %b want 000000", {bus.coeff_push_o, bus.signal_push_o,
                     bus.coeff_ready_o, bus.sample_ready_o, bus.result_valid_o, bus.busy_o});
        end
        @(posedge clk);
        #3;
        rstn = 1'b1;
        next_cycle();
        prev_c_hs = 1'b0; prev_s_hs = 1'b0; last_c = '0; last_s = '0; model_loaded = 1'b0;
        checks++;
        if (bus.coeff_push_o !== 1'b0 || bus.signal_push_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_release_push: got %b%b want 00", bus.coeff_push_o, bus.signal_push_o);
        end
        fill_random();
        cfg_reload = 1'b0;
        run_frame();
    endtask

    task automatic test_drain_restart();
        $display("[TB] test_drain_restart");
        set_defaults();
        fill_random();
        cfg_drain_toggle = 1'b1;
        run_frame();
    endtask

`ifdef MAC_LOADER_COEFF_RELOAD_EN
    task automatic test_reload();
        $display("[TB] test_reload");
        set_defaults();
        fill_random();
        cfg_reload = 1'b1;
        run_frame();
        fill_random();
        cfg_reload = 1'b0;
        run_frame();
    endtask
`endif

    task automatic test_back_to_back();
        $display("[TB] test_back_to_back");
        for (int f = 0; f < 8; f++) begin
            set_defaults();
            fill_random();
            cfg_valid_pct    = int'($urandom_range(100, 50));
            cfg_full_pct     = int'($urandom_range(40));
            cfg_rready_delay = int'($urandom_range(3));
            cfg_empty_delay  = int'($urandom_range(3));
            cfg_reload       = 1'($urandom_range(1));
            run_frame();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_backpressure();
        test_result_backpressure();
        test_reset_mid();
        test_drain_restart();
`ifdef MAC_LOADER_COEFF_RELOAD_EN
        test_reload();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
